// File: rtl/flash_program_sequencer_if.sv
// Command and flash-bus bundle for flash_program_sequencer.
//   slave  : the sequencer's view (takes commands, drives the flash pins,
//            requests the PRG bus).
//   master : the requester / board view (issues commands, answers the
//            bus request and supplies flash read data).
// Signals:
//   cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_data : single-command request
//   bus_req/bus_grant                            : PRG bus arbitration
//   fl_addr/fl_dout/fl_din/fl_ce_n/fl_oe_n/fl_we_n : flash pins
//   busy/done/error                              : operation status
interface flash_program_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 27
) ();
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [7:0]            cmd_data;
  logic                  bus_req;
  logic                  bus_grant;
  logic [ADDR_WIDTH-1:0] fl_addr;
  logic [7:0]            fl_dout;
  logic [7:0]            fl_din;
  logic                  fl_ce_n;
  logic                  fl_oe_n;
  logic                  fl_we_n;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, bus_grant, fl_din,
    output cmd_ready, bus_req, fl_addr, fl_dout, fl_ce_n, fl_oe_n, fl_we_n,
           busy, done, error
  );

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, bus_grant, fl_din,
    input  cmd_ready, bus_req, fl_addr, fl_dout, fl_ce_n, fl_oe_n, fl_we_n,
           busy, done, error
  );
endinterface

// File: rtl/flash_program_sequencer.sv
// JEDEC command sequencer for the PRG flash (x8). Accepts one command at a
// time (program, sector erase, chip erase, reset/F0), emits the unlock and
// command write cycles, then polls DQ7/DQ5 until the operation completes,
// fails, or the poll counter saturates. Failures issue an F0 write and set
// the sticky error flag. The flash pins are only driven active while the
// PRG bus is granted; grant is sampled at transaction boundaries only.
// Ports:
//   m2      : clock
//   reset_n : asynchronous active-low reset
//   bus     : command / arbitration / flash pin bundle (slave modport)
module flash_program_sequencer #(
  parameter int unsigned ADDR_WIDTH    = 27,
  parameter int unsigned TIMEOUT_WIDTH = 24
) (
  input  logic                     m2,
  input  logic                     reset_n,
  flash_program_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    OP_PROG   = 2'd0,
    OP_SECTOR = 2'd1,
    OP_CHIP   = 2'd2,
    OP_RESET  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD,
    RD_OE,
    RD_SAMPLE,
    DONE
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] A_AAA = ADDR_WIDTH'(12'hAAA);
  localparam logic [ADDR_WIDTH-1:0] A_555 = ADDR_WIDTH'(12'h555);

  state_e                   state;
  op_e                      op_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [7:0]               data_q;
  logic [2:0]               step_q;      // index of the next sequence write
  logic                     abort_q;     // issuing the error-path F0 write
  logic                     recheck_q;   // DQ5 seen, one confirming re-read
  logic                     pend_rd_q;   // transaction waiting in REQ is a read
  logic [TIMEOUT_WIDTH-1:0] poll_cnt_q;

  logic [2:0]               seq_len;
  logic                     abort_mode;
  logic [ADDR_WIDTH-1:0]    wr_addr;
  logic [7:0]               wr_data;
  logic [ADDR_WIDTH-1:0]    poll_addr;
  logic                     exp_dq7;
  logic                     dq7_ok;
  logic [TIMEOUT_WIDTH-1:0] cnt_inc;
  logic                     launch_wr;
  logic                     launch_rd;
  logic                     to_done;
  logic                     set_abort;
  logic                     set_recheck;

  // Sequence tables: length, and address/data of write step_q.
  always_comb begin
    case (op_q)
      OP_PROG:  seq_len = 3'd4;
      OP_RESET: seq_len = 3'd1;
      default:  seq_len = 3'd6;
    endcase
  end

  always_comb begin
    wr_addr = '0;
    wr_data = 8'hF0;
    if (!abort_mode && op_q != OP_RESET) begin
      case (step_q)
        3'd0: begin wr_addr = A_AAA; wr_data = 8'hAA; end
        3'd1: begin wr_addr = A_555; wr_data = 8'h55; end
        3'd2: begin
          wr_addr = A_AAA;
          wr_data = (op_q == OP_PROG) ? 8'hA0 : 8'h80;
        end
        3'd3: begin
          if (op_q == OP_PROG) begin
            wr_addr = addr_q;
            wr_data = data_q;
          end else begin
            wr_addr = A_AAA;
            wr_data = 8'hAA;
          end
        end
        3'd4: begin wr_addr = A_555; wr_data = 8'h55; end
        default: begin
          if (op_q == OP_SECTOR) begin
            wr_addr = addr_q;
            wr_data = 8'h30;
          end else begin
            wr_addr = A_AAA;
            wr_data = 8'h10;
          end
        end
      endcase
    end
  end

  always_comb begin
    poll_addr = (op_q == OP_CHIP) ? '0 : addr_q;
    exp_dq7   = (op_q == OP_PROG) ? data_q[7] : 1'b1;
    dq7_ok    = (bus.fl_din[7] == exp_dq7);
    cnt_inc   = poll_cnt_q + 1'b1;
  end

  // Decide what follows the current cycle. Transactions run back to back,
  // so the next one is launched on the same edge that ends the current one;
  // the grant check for that launch happens in the sequential block.
  always_comb begin
    launch_wr   = 1'b0;
    launch_rd   = 1'b0;
    to_done     = 1'b0;
    set_abort   = 1'b0;
    set_recheck = 1'b0;
    case (state)
      REQ: begin
        if (pend_rd_q) launch_rd = 1'b1;
        else           launch_wr = 1'b1;
      end
      WR_HOLD: begin
        if (abort_q || step_q == seq_len) begin
          if (abort_q || op_q == OP_RESET) to_done   = 1'b1;
          else                             launch_rd = 1'b1;
        end else begin
          launch_wr = 1'b1;
        end
      end
      RD_SAMPLE: begin
        if (dq7_ok) begin
          to_done = 1'b1;
        end else if ((&cnt_inc) || recheck_q) begin
          set_abort = 1'b1;
          launch_wr = 1'b1;
        end else begin
          launch_rd   = 1'b1;
          set_recheck = bus.fl_din[5];
        end
      end
      default: ;
    endcase
    abort_mode = abort_q | set_abort;
  end

  always_ff @(posedge m2 or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      op_q          <= OP_PROG;
      addr_q        <= '0;
      data_q        <= '0;
      step_q        <= '0;
      abort_q       <= 1'b0;
      recheck_q     <= 1'b0;
      pend_rd_q     <= 1'b0;
      poll_cnt_q    <= '0;
      bus.cmd_ready <= 1'b1;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.error     <= 1'b0;
      bus.bus_req   <= 1'b0;
      bus.fl_ce_n   <= 1'b1;
      bus.fl_oe_n   <= 1'b1;
      bus.fl_we_n   <= 1'b1;
      bus.fl_addr   <= '0;
      bus.fl_dout   <= '0;
    end else begin
      bus.done <= 1'b0;

      case (state)
        IDLE, DONE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            op_q          <= op_e'(bus.cmd_op);
            addr_q        <= bus.cmd_addr;
            data_q        <= bus.cmd_data;
            step_q        <= '0;
            abort_q       <= 1'b0;
            recheck_q     <= 1'b0;
            pend_rd_q     <= 1'b0;
            poll_cnt_q    <= '0;
            bus.busy      <= 1'b1;
            bus.bus_req   <= 1'b1;
            bus.error     <= 1'b0;
            bus.cmd_ready <= 1'b0;
            state         <= REQ;
          end else begin
            state <= IDLE;
          end
        end
        WR_SETUP: begin
          bus.fl_we_n <= 1'b0;
          state       <= WR_STROBE;
        end
        WR_STROBE: begin
          bus.fl_we_n <= 1'b1;
          state       <= WR_HOLD;
        end
        WR_HOLD: begin
          bus.fl_ce_n <= 1'b1;
        end
        RD_OE: begin
          state <= RD_SAMPLE;
        end
        RD_SAMPLE: begin
          bus.fl_ce_n <= 1'b1;
          bus.fl_oe_n <= 1'b1;
          poll_cnt_q  <= cnt_inc;
          if (set_recheck) recheck_q <= 1'b1;
        end
        default: ;
      endcase

      if (set_abort) begin
        abort_q   <= 1'b1;
        bus.error <= 1'b1;
      end

      if (to_done) begin
        state         <= DONE;
        bus.done      <= 1'b1;
        bus.busy      <= 1'b0;
        bus.bus_req   <= 1'b0;
        bus.cmd_ready <= 1'b1;
      end

      // Launch overrides the strobe release above so back-to-back
      // transactions keep ce_n low; without grant, park in REQ.
      if (launch_wr || launch_rd) begin
        if (bus.bus_grant) begin
          bus.fl_ce_n <= 1'b0;
          if (launch_rd) begin
            bus.fl_oe_n <= 1'b0;
            bus.fl_addr <= poll_addr;
            state       <= RD_OE;
          end else begin
            bus.fl_addr <= wr_addr;
            bus.fl_dout <= wr_data;
            if (!abort_mode) step_q <= step_q + 3'd1;
            state       <= WR_SETUP;
          end
        end else begin
          pend_rd_q <= launch_rd;
          state     <= REQ;
        end
      end
    end
  end

endmodule

// File: tb/tb_flash_program_sequencer.sv
module tb_flash_program_sequencer;
  localparam int unsigned AW   = 27;
  localparam int unsigned TW   = 4;
  localparam int          TMAX = (1 << TW) - 1;

  logic m2 = 1'b0;
  logic reset_n = 1'b0;

  flash_program_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

  flash_program_sequencer #(.ADDR_WIDTH(AW), .TIMEOUT_WIDTH(TW)) dut (
    .m2      (m2),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 m2 = ~m2;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]      resp_q[$];   // flash model answers, one per read; last repeats
  int              stall_q[$];  // edges (relative to acceptance) with grant low
  logic [AW+7:0]   wr_log[$];
  logic [AW-1:0]   rd_log[$];
  int              oe_cycles;
  logic            prev_we = 1'b1;

  logic [AW+7:0]   exp_w[$];
  int              exp_r;
  logic            exp_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] resp_at(input int i);
    if (resp_q.size() == 0) return 8'hFF;
    if (i >= resp_q.size()) return resp_q[resp_q.size()-1];
    return resp_q[i];
  endfunction

  function automatic logic [AW+7:0] mkw(input logic [AW-1:0] a, input logic [7:0] d);
    return {a, d};
  endfunction

  // One clock: wait for the falling edge, observe the flash pins, then
  // present read data for the read currently in progress.
  task automatic step();
    int idx;
    @(negedge m2);
    if (bus.fl_we_n == 1'b0) begin
      chk("we_width", prev_we, 1'b1);
      chk("we_oe_excl", bus.fl_oe_n, 1'b1);
      chk("we_ce", bus.fl_ce_n, 1'b0);
      wr_log.push_back({bus.fl_addr, bus.fl_dout});
    end
    if (bus.fl_oe_n == 1'b0) begin
      oe_cycles++;
      chk("oe_ce", bus.fl_ce_n, 1'b0);
      if (oe_cycles % 2 == 1) rd_log.push_back(bus.fl_addr);
      else chk("rd_addr_stable", bus.fl_addr, rd_log[rd_log.size()-1]);
    end
    prev_we = bus.fl_we_n;
    idx = (oe_cycles == 0) ? 0 : (oe_cycles - 1) / 2;
    bus.fl_din = resp_at(idx);
  endtask

  // Expected write list, read count and error outcome from the JEDEC rules.
  task automatic model(input logic [1:0] op, input logic [AW-1:0] a, input logic [7:0] d);
    logic       e7;
    logic       rechk;
    logic [7:0] r;
    exp_w.delete();
    exp_r   = 0;
    exp_err = 1'b0;
    if (op == 2'd3) begin
      exp_w.push_back(mkw('0, 8'hF0));
    end else begin
      exp_w.push_back(mkw(AW'(12'hAAA), 8'hAA));
      exp_w.push_back(mkw(AW'(12'h555), 8'h55));
      if (op == 2'd0) begin
        exp_w.push_back(mkw(AW'(12'hAAA), 8'hA0));
        exp_w.push_back(mkw(a, d));
      end else begin
        exp_w.push_back(mkw(AW'(12'hAAA), 8'h80));
        exp_w.push_back(mkw(AW'(12'hAAA), 8'hAA));
        exp_w.push_back(mkw(AW'(12'h555), 8'h55));
        exp_w.push_back((op == 2'd1) ? mkw(a, 8'h30) : mkw(AW'(12'hAAA), 8'h10));
      end
      e7    = (op == 2'd0) ? d[7] : 1'b1;
      rechk = 1'b0;
      for (int i = 0; i < 64; i++) begin
        r = resp_at(i);
        exp_r++;
        if (r[7] == e7) break;
        if (exp_r == TMAX || rechk) begin
          exp_err = 1'b1;
          break;
        end
        rechk = r[5];
      end
      if (exp_err) exp_w.push_back(mkw('0, 8'hF0));
    end
  endtask

  function automatic bit stalled(input int e);
    foreach (stall_q[i]) if (stall_q[i] == e) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run(input logic [1:0] op, input logic [AW-1:0] a, input logic [7:0] d,
                     input string tag);
    int       k;
    bit       seen;
    logic     pce;
    logic     g;
    logic [AW-1:0] rexp;
    model(op, a, d);
    wr_log.delete();
    rd_log.delete();
    oe_cycles = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = a;
    bus.cmd_data  = d;
    step();  // observed after acceptance edge E0
    bus.cmd_valid = 1'b0;
    chk({tag, "_busy"}, bus.busy, 1'b1);
    chk({tag, "_req"}, bus.bus_req, 1'b1);
    chk({tag, "_rdy0"}, bus.cmd_ready, 1'b0);
    chk({tag, "_errclr"}, bus.error, 1'b0);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 400) begin
      bus.bus_grant = !stalled(k + 1);
      pce = bus.fl_ce_n;
      g   = bus.bus_grant;
      step();
      k++;
      if (!g && pce) chk({tag, "_nostrobe"}, bus.fl_ce_n, 1'b1);
      if (bus.done) seen = 1'b1;
    end
    bus.bus_grant = 1'b1;
    chk({tag, "_done_seen"}, seen, 1'b1);
    chk({tag, "_latency"}, k, 3 * exp_w.size() + 2 * exp_r + 1 + stall_q.size());
    chk({tag, "_error"}, bus.error, exp_err);
    chk({tag, "_busy_off"}, bus.busy, 1'b0);
    chk({tag, "_rdy1"}, bus.cmd_ready, 1'b1);
    chk({tag, "_req_off"}, bus.bus_req, 1'b0);
    chk({tag, "_nwr"}, wr_log.size(), exp_w.size());
    foreach (exp_w[i])
      if (i < wr_log.size()) chk($sformatf("%s_wr%0d", tag, i), wr_log[i], exp_w[i]);
    chk({tag, "_oe_cycles"}, oe_cycles, 2 * exp_r);
    rexp = (op == 2'd2) ? '0 : a;
    foreach (rd_log[i]) chk($sformatf("%s_rd%0d", tag, i), rd_log[i], rexp);
    step();
    chk({tag, "_done_pulse"}, bus.done, 1'b0);
    step();
    chk({tag, "_err_hold"}, bus.error, exp_err);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy"}, bus.cmd_ready, 1'b1);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_done"}, bus.done, 1'b0);
    chk({tag, "_req"}, bus.bus_req, 1'b0);
    chk({tag, "_strobes"}, {bus.fl_ce_n, bus.fl_oe_n, bus.fl_we_n}, 3'b111);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    op;
    logic [AW-1:0] a;
    logic [7:0]    d;
    logic [7:0]    r;
    logic          e7;
    int            nr;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_addr  = '0;
    bus.cmd_data  = '0;
    bus.bus_grant = 1'b1;
    bus.fl_din    = 8'hFF;
    oe_cycles     = 0;
    repeat (3) @(negedge m2);
    chk_reset_vals("rst");
    chk("rst_error", bus.error, 1'b0);
    chk("rst_addr", bus.fl_addr, '0);
    chk("rst_dout", bus.fl_dout, '0);
    reset_n = 1'b1;
    step();
    chk_reset_vals("rst_rel");

    // program, ready on first read
    resp_q = '{8'h5A};
    run(2'd0, 27'h0012345, 8'h5A, "prog");

    // sector erase, ready on 4th poll
    resp_q = '{8'h00, 8'h00, 8'h00, 8'hFF};
    run(2'd1, 27'h0400000, 8'h00, "sector");

    // DQ5 failure then recovery of error on next command
    resp_q = '{8'h20};
    run(2'd0, 27'h0000100, 8'h80, "dq5");
    resp_q = '{8'hFF};
    run(2'd2, 27'h1234567, 8'h00, "chip");

    // reset op
    run(2'd3, 27'h7654321, 8'h00, "f0");

    // arbitration stalls: 5 at start, 2 between writes 2 and 3
    stall_q = '{1, 2, 3, 4, 5, 12, 13};
    resp_q  = '{8'h33};
    run(2'd0, 27'h0055555, 8'h33, "stall");
    stall_q.delete();

    // timeout: never ready
    resp_q = '{8'h00};
    run(2'd0, 27'h0000042, 8'h80, "timeout");

    // async reset during WR_STROBE of write 3
    resp_q = '{8'h11};
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd0;
    bus.cmd_addr  = 27'h0000777;
    bus.cmd_data  = 8'h11;
    step();
    bus.cmd_valid = 1'b0;
    repeat (8) step();
    chk("midrst_we_low", bus.fl_we_n, 1'b0);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    #1;
    reset_n = 1'b1;
    prev_we = 1'b1;
    run(2'd0, 27'h0000777, 8'h11, "after_rst");

    // randomized commands
    for (int t = 0; t < 10; t++) begin
      op = 2'($urandom_range(0, 3));
      a  = AW'($urandom);
      d  = 8'($urandom);
      e7 = (op == 2'd0) ? d[7] : 1'b1;
      resp_q.delete();
      nr = $urandom_range(0, 3);
      for (int i = 0; i < nr; i++) begin
        r    = 8'($urandom);
        r[7] = ~e7;
        resp_q.push_back(r);
      end
      r    = 8'($urandom);
      r[7] = e7;
      resp_q.push_back(r);
      stall_q.delete();
      nr = $urandom_range(0, 2);
      for (int i = 1; i <= nr; i++) stall_q.push_back(i);
      run(op, a, d, $sformatf("rnd%0d", t));
    end
    stall_q.delete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/flash_program_sequencer.md
# flash_program_sequencer

Sequences JEDEC command cycles to the PRG flash for byte program, sector erase, chip erase and reset (F0) operations. Mapper or loader logic issues single-command requests; the block generates the unlock/command write sequence and DQ7/DQ5 data polling. It requests the flash bus from the PRG bus arbiter and drives the flash control pins only while granted. All timing is counted in m2 cycles.

## Interface
- ADDR_WIDTH, 27, flash byte address width (x8 mode).
- TIMEOUT_WIDTH, 24, width of the poll-read counter; saturation means timeout.
- m2  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high when idle; a command is accepted on an edge with cmd_valid & cmd_ready.
- cmd_op  in  2  0 program, 1 sector erase, 2 chip erase, 3 reset (F0).
- cmd_addr  in  ADDR_WIDTH  program or sector address.
- cmd_data  in  8  program data.
- bus_req  out  1  flash bus request to the arbiter.
- bus_grant  in  1  flash bus granted.
- fl_addr  out  ADDR_WIDTH  flash address.
- fl_dout  out  8  write data; the top level drives the bus only while fl_we_n is low.
- fl_din  in  8  flash read data.
- fl_ce_n, fl_oe_n, fl_we_n  out  1 each  flash strobes.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky failure flag.

## Operation
- Reset values: cmd_ready=1, busy=0, done=0, error=0, bus_req=0, fl_ce_n=fl_oe_n=fl_we_n=1, fl_addr=0, fl_dout=0.
- On accept:
  - Latch op, addr and data.
  - Set busy=1 and bus_req=1; clear error.
  - cmd_ready=0 until DONE.
- States: IDLE, REQ, WR_SETUP, WR_STROBE, WR_HOLD, RD_OE, RD_SAMPLE, DONE.
- Write transaction (3 cycles), with fl_addr/fl_dout stable across all three:
  - WR_SETUP: ce_n=0, we_n=1.
  - WR_STROBE: we_n=0.
  - WR_HOLD: we_n=1.
  - ce_n returns to 1 after WR_HOLD.
- Read transaction (2 cycles): RD_OE drives ce_n=0, oe_n=0; RD_SAMPLE keeps both low, and fl_din is captured on the edge leaving RD_SAMPLE.
- bus_grant is sampled only when starting a transaction (from REQ or between transactions). If it is low, the block waits with all strobes high and bus_req held. A started transaction always completes.
- Write sequences (address:data):
  - program: AAA:AA, 555:55, AAA:A0, addr:data.
  - sector erase: AAA:AA, 555:55, AAA:80, AAA:AA, 555:55, addr:30.
  - chip erase: AAA:AA, 555:55, AAA:80, AAA:AA, 555:55, AAA:10.
  - reset: any address (0):F0. No polling; go straight to DONE.
- Polling:
  - Read target: addr for program and sector erase, 0 for chip erase.
  - Expected DQ7: data[7] for program, 1 for erase.
  - DQ7 match: go to DONE.
  - DQ7 mismatch with DQ5=0: poll again.
  - DQ7 mismatch with DQ5=1: one re-read; if DQ7 still mismatches, take the error path.
- Timeout: poll counter increments per read. When it reaches all-ones, take the error path.
- Error path: set error=1, issue one F0 write, then DONE.
- DONE (one cycle): done=1, busy=0, bus_req=0, cmd_ready=1; the next state is IDLE. A command may be accepted in DONE.
- Async reset mid-operation: outputs return to reset values immediately. The flash is left mid-operation; software issues op 3.

## Timing
- Edge E0 = acceptance edge. bus_req is high after E0.
- With bus_grant high at E1:
  - First WR_SETUP is visible after E1.
  - Program writes occupy E1–E12, the first poll E13–E14, and data is captured at E15.
  - Program with ready flash: done high after E15, cmd_ready=1 in the same cycle.
  - Sector/chip erase ready on the first poll: done after E21.
  - Reset op: done after E4.
- Each cycle bus_grant is low at a transaction boundary adds exactly one cycle.
- fl_we_n low for exactly 1 cycle per write; fl_oe_n low for exactly 2 cycles per read. fl_oe_n and fl_we_n are never both low.
- error is unchanged from DONE until the next acceptance edge.

## Test plan
- Program addr 0x012345, data 0x5A; grant tied high; model ready on first read (returns 0x5A) -> writes AAA:AA, 555:55, AAA:A0, 012345:5A; one read of 012345; done pulse after E15; error=0.
- Sector erase at 0x0400000; model returns 0x00 for 3 polls, then 0xFF -> six writes ending 0400000:30; exactly 4 reads; done; error=0.
- Program data 0x80; model returns 0x20 (DQ7=0, DQ5=1) twice -> two reads, then F0 write; done; error=1. A new accepted command clears error.
- bus_grant low for 5 cycles after E0, then toggled low for 2 cycles between writes 2 and 3 -> no strobe while low; transactions are never split; done delayed by exactly 7 cycles.
- TIMEOUT_WIDTH=4, model never ready -> 15 polls, F0 write, error=1, done.
- reset_n pulsed low during WR_STROBE of write 3 -> fl_we_n/ce_n go high immediately; busy=0, cmd_ready=1, bus_req=0; the next program runs normally.
